// File: rtl/memory_arbiter_pkg.sv
// ==========================================================================
// memory_arbiter_pkg: shared types for the RAM arbiter  (rev 1.0)
// ==========================================================================
`default_nettype none
package memory_arbiter_pkg;
  // Values mirror MemArbiterDefs.v.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LDR = 1'b1;
endpackage
`default_nettype wire

// File: rtl/MemArbiterDefs.v
// ==========================================================================
// MemArbiterDefs: state and owner encodings for memory_arbiter  (rev 1.0)
// ==========================================================================
`ifndef MEM_ARBITER_DEFS_V
`define MEM_ARBITER_DEFS_V
`define MA_ST_IDLE    2'd0
`define MA_ST_ACCESS  2'd1
`define MA_ST_CAPTURE 2'd2
`define MA_ST_ACK     2'd3
`define MA_OWNER_CPU  1'b0
`define MA_OWNER_LDR  1'b1
`endif

// File: rtl/memory_arbiter_rr_pick2.sv
// ==========================================================================
// rr_pick2: two-way round-robin winner select with port-1 lock  (rev 1.0)
// ==========================================================================
`default_nettype none
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic lock,
  output logic winner,
  output logic valid
);
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      // Lock only keeps port 1 once it already holds the bus.
      winner = last_owner ? lock : 1'b1;
    end else begin
      winner = req1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
// ==========================================================================
// memory_arbiter: CPU/loader arbiter for the single-port RAM  (rev 1.0)
// ==========================================================================
`default_nettype none
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET_n,
  input  logic                  i_CPU_REQ,
  input  logic                  i_CPU_WE,
  input  logic [ADDR_WIDTH-1:0] i_CPU_ADDR,
  input  logic [DATA_WIDTH-1:0] i_CPU_WDATA,
  output logic                  o_CPU_ACK,
  input  logic                  i_LDR_REQ,
  input  logic                  i_LDR_WE,
  input  logic [ADDR_WIDTH-1:0] i_LDR_ADDR,
  input  logic [DATA_WIDTH-1:0] i_LDR_WDATA,
  input  logic                  i_LDR_LOCK,
  output logic                  o_LDR_ACK,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_RAM_CE,
  output logic                  o_RAM_WE,
  output logic [ADDR_WIDTH-1:0] o_RAM_ADDR,
  output logic [DATA_WIDTH-1:0] o_RAM_WDATA,
  input  logic [DATA_WIDTH-1:0] i_RAM_RDATA,
  output logic                  o_BUSY,
  output logic                  o_OWNER
);
  state_t state;
  logic   acc_we;
  logic   pick_winner;
  logic   pick_valid;

  rr_pick2 u_pick (
    .req0       (i_CPU_REQ),
    .req1       (i_LDR_REQ),
    .last_owner (o_OWNER),
    .lock       (i_LDR_LOCK),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  always_ff @(posedge i_CLOCK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state       <= ST_IDLE;
      acc_we      <= 1'b0;
      o_CPU_ACK   <= 1'b0;
      o_LDR_ACK   <= 1'b0;
      o_RDATA     <= '0;
      o_RAM_CE    <= 1'b0;
      o_RAM_WE    <= 1'b0;
      o_RAM_ADDR  <= '0;
      o_RAM_WDATA <= '0;
      o_BUSY      <= 1'b0;
      o_OWNER     <= OWNER_LDR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            o_OWNER  <= pick_winner;
            o_RAM_CE <= 1'b1;
            o_BUSY   <= 1'b1;
            state    <= ST_ACCESS;
            if (pick_winner == OWNER_LDR) begin
              o_RAM_WE    <= i_LDR_WE;
              acc_we      <= i_LDR_WE;
              o_RAM_ADDR  <= i_LDR_ADDR;
              o_RAM_WDATA <= i_LDR_WDATA;
            end else begin
              o_RAM_WE    <= i_CPU_WE;
              acc_we      <= i_CPU_WE;
              o_RAM_ADDR  <= i_CPU_ADDR;
              o_RAM_WDATA <= i_CPU_WDATA;
            end
          end
        end
        ST_ACCESS: begin
          o_RAM_CE <= 1'b0;
          o_RAM_WE <= 1'b0;
          state    <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // RAM output is valid now; writes keep the previous read data.
          if (!acc_we) o_RDATA <= i_RAM_RDATA;
          o_CPU_ACK <= (o_OWNER == OWNER_CPU);
          o_LDR_ACK <= (o_OWNER == OWNER_LDR);
          state     <= ST_ACK;
        end
        ST_ACK: begin
          o_CPU_ACK <= 1'b0;
          o_LDR_ACK <= 1'b0;
          o_BUSY    <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          o_RAM_CE  <= 1'b0;
          o_RAM_WE  <= 1'b0;
          o_CPU_ACK <= 1'b0;
          o_LDR_ACK <= 1'b0;
          o_BUSY    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ==========================================================================
// tb_memory_arbiter: directed self-checking bench for memory_arbiter  (rev 1.0)
// ==========================================================================
`default_nettype none
module tb_memory_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [3:0] cpu_addr, ldr_addr;
  logic [7:0] cpu_wdata, ldr_wdata;
  logic       cpu_ack, ldr_ack, ram_ce, ram_we, busy, owner;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;
  logic [7:0] mem [16];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .i_CLOCK(clk), .i_RESET_n(rst_n),
    .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr),
    .i_CPU_WDATA(cpu_wdata), .o_CPU_ACK(cpu_ack),
    .i_LDR_REQ(ldr_req), .i_LDR_WE(ldr_we), .i_LDR_ADDR(ldr_addr),
    .i_LDR_WDATA(ldr_wdata), .i_LDR_LOCK(ldr_lock), .o_LDR_ACK(ldr_ack),
    .o_RDATA(rdata), .o_RAM_CE(ram_ce), .o_RAM_WE(ram_we),
    .o_RAM_ADDR(ram_addr), .o_RAM_WDATA(ram_wdata), .i_RAM_RDATA(ram_rdata),
    .o_BUSY(busy), .o_OWNER(owner)
  );

  // Synchronous single-port RAM: read data appears the cycle after the CE edge.
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'hA5;
    ram_rdata = 8'h00;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
    tick(); tick();

    // Reset state
    chk("rst_ce", ram_ce, 0);     chk("rst_we", ram_we, 0);
    chk("rst_ack", {cpu_ack, ldr_ack}, 0);
    chk("rst_busy", busy, 0);     chk("rst_owner", owner, 1);
    chk("rst_rdata", rdata, 0);   chk("rst_addr", ram_addr, 0);
    rst_n = 1'b1;
    tick();

    // CPU read of addr 3
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
    tick();
    chk("rd_ce_k", ram_ce, 1);    chk("rd_addr", ram_addr, 4'h3);
    chk("rd_busy", busy, 1);      chk("rd_owner", owner, 0);
    chk("rd_we", ram_we, 0);
    tick();
    chk("rd_ce_k1", ram_ce, 0);   chk("rd_ack_early", cpu_ack, 0);
    tick();
    chk("rd_ack", cpu_ack, 1);    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_ldr_ack", ldr_ack, 0);
    cpu_req = 0;
    tick();
    chk("rd_ack_end", cpu_ack, 0); chk("rd_idle", busy, 0);

    // Loader write 0x3C to addr 0xF
    ldr_req = 1; ldr_we = 1; ldr_addr = 4'hF; ldr_wdata = 8'h3C;
    tick();
    chk("wr_ce", ram_ce, 1);      chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 4'hF); chk("wr_owner", owner, 1);
    tick();
    chk("wr_we_drop", ram_we, 0);
    tick();
    chk("wr_ack", ldr_ack, 1);    chk("wr_cpu_ack", cpu_ack, 0);
    chk("wr_rdata_keep", rdata, 8'hA5);
    ldr_req = 0; ldr_we = 0;
    tick();
    chk("wr_mem", mem[15], 8'h3C);

    // Both requesting, lock low: CPU, LDR, CPU, LDR
    cpu_req = 1; cpu_addr = 4'h1;
    ldr_req = 1; ldr_addr = 4'h2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_owner", owner, i % 2);
      tick(); tick();
      chk("rr_cpu_ack", cpu_ack, (i % 2 == 0));
      chk("rr_ldr_ack", ldr_ack, (i % 2 == 1));
      chk("rr_rdata", rdata, (i % 2 == 0) ? 8'h11 : 8'h22);
      tick();
    end

    // Loader holds the bus under lock for three grants
    ldr_lock = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lk_owner", owner, 1);
      tick(); tick();
      chk("lk_ldr_ack", ldr_ack, 1);
      chk("lk_cpu_ack", cpu_ack, 0);
      tick();
    end
    ldr_lock = 0;
    tick();
    chk("unlk_owner", owner, 0);
    tick(); tick();
    chk("unlk_cpu_ack", cpu_ack, 1);
    cpu_req = 0; ldr_req = 0;
    tick();

    // Reset pulsed during ACCESS of a CPU read
    cpu_req = 1; cpu_addr = 4'h3;
    tick();
    chk("ar_ce_pre", ram_ce, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ce", ram_ce, 0);      chk("ar_busy", busy, 0);
    chk("ar_owner", owner, 1);    chk("ar_rdata", rdata, 0);
    tick();
    chk("ar_no_ack", cpu_ack, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_regrant", ram_ce, 1);
    tick();
    chk("ar_no_ack2", cpu_ack, 0);
    tick();
    chk("ar_ack", cpu_ack, 1);    chk("ar_rdata2", rdata, 8'hA5);
    cpu_req = 0;
    tick();

    // CPU request arriving during a loader ACK waits for IDLE
    ldr_req = 1; ldr_we = 0; ldr_addr = 4'h2;
    tick(); tick(); tick();
    chk("ov_ldr_ack", ldr_ack, 1);
    ldr_req = 0;
    cpu_req = 1; cpu_addr = 4'h1;
    tick();
    chk("ov_no_grant_ce", ram_ce, 0); chk("ov_owner_hold", owner, 1);
    chk("ov_idle", busy, 0);
    tick();
    chk("ov_grant_ce", ram_ce, 1);    chk("ov_owner", owner, 0);
    tick(); tick();
    chk("ov_cpu_ack", cpu_ack, 1);    chk("ov_rdata", rdata, 8'h11);
    cpu_req = 0;
    tick();

    // Request withdrawn before it could be granted: no access
    chk("wd_idle", busy, 0);
    tick();
    chk("wd_ce", ram_ce, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter for the single-port program/data RAM. It shares the RAM between the CPU control path (requester 0) and the program loader (requester 1). The arbiter sits between both requesters and the RAM macro and owns all RAM control lines. Each request completes through a registered 4-state access sequence, with round-robin fairness and an optional loader burst lock.

## Interface
Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width (matches IMM4 addressing)

Ports (one clock; reset is asynchronous and active-low):
- i_CLOCK  in  1  clock; all state updates on rising edge
- i_RESET_n  in  1  asynchronous active-low reset
- i_CPU_REQ  in  1  CPU request, held until ack
- i_CPU_WE  in  1  CPU write enable (1 = write)
- i_CPU_ADDR  in  ADDR_WIDTH  CPU address
- i_CPU_WDATA  in  DATA_WIDTH  CPU write data
- o_CPU_ACK  out  1  one-cycle completion pulse to CPU
- i_LDR_REQ, i_LDR_WE, i_LDR_ADDR, i_LDR_WDATA  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same meaning as CPU fields
- i_LDR_LOCK  in  1  loader burst lock
- o_LDR_ACK  out  1  one-cycle completion pulse to loader
- o_RDATA  out  DATA_WIDTH  read data, shared by both requesters
- o_RAM_CE, o_RAM_WE  out  1  RAM chip enable and write enable
- o_RAM_ADDR  out  ADDR_WIDTH  RAM address
- o_RAM_WDATA  out  DATA_WIDTH  RAM write data
- i_RAM_RDATA  in  DATA_WIDTH  RAM read data, valid the cycle after the CE edge
- o_BUSY  out  1  high in every state except IDLE
- o_OWNER  out  1  current or last granted requester (0 = CPU, 1 = loader)

## Operation
- States: IDLE, ACCESS, CAPTURE, ACK.
- Requester contract:
  - WE, ADDR and WDATA stay stable while REQ is high.
  - REQ stays high until the requester sees ACK.
  - REQ must be deasserted, or a new request presented, by the edge that ends the ACK cycle.
- IDLE, no REQ high: remain in IDLE.
- IDLE, exactly one REQ high: grant that requester.
- IDLE, both REQ high: grant the requester that is not o_OWNER (round-robin), with one exception:
  - If o_OWNER = 1, i_LDR_LOCK = 1 and i_LDR_REQ = 1, the loader wins.
  - i_LDR_LOCK has no effect when o_OWNER = 0.
- On grant: latch the owner into o_OWNER; register o_RAM_CE = 1, o_RAM_WE = owner WE, and owner ADDR/WDATA onto the RAM pins; go to ACCESS.
- ACCESS: the RAM samples on the closing edge. On that edge clear o_RAM_CE and o_RAM_WE; go to CAPTURE.
- CAPTURE: on the closing edge, load o_RDATA from i_RAM_RDATA (reads only; writes leave o_RDATA unchanged), set the owner's ACK, go to ACK.
- ACK: the owner's ACK is high for exactly this cycle. REQ inputs are ignored. On the closing edge, clear ACK and go to IDLE.
- o_RDATA holds its value until the next read completes.
- Illegal state encoding: return to IDLE on the next edge.

## Timing
- Reset values, applied immediately when i_RESET_n falls:
  - state = IDLE
  - o_CPU_ACK = o_LDR_ACK = 0, o_RAM_CE = o_RAM_WE = 0, o_RAM_ADDR = 0, o_RAM_WDATA = 0, o_RDATA = 0, o_BUSY = 0
  - o_OWNER = 1, so the CPU wins the first tie
- Request first seen high in IDLE at edge k:
  - CE high during cycle k..k+1
  - ACK high during cycle k+2..k+3
  - next grant evaluated at edge k+4
- Throughput: one access per 4 cycles, with no bubble beyond that.
- Both requesters continuously requesting, lock low: grants alternate CPU, LDR, CPU, ...
- REQ dropped before it is granted: no access occurs.
- REQ dropped by the owner after the grant: the sequence completes and ACK is still pulsed.
- Reset mid-ACCESS: CE/WE drop asynchronously. The write is lost unless the RAM edge has already occurred. No ACK is issued.
- All outputs are registered; none is a combinational function of the inputs.

## Structure
- Shared include file rtl/MemArbiterDefs.v holds:
  - state encodings (2-bit): IDLE=0, ACCESS=1, CAPTURE=2, ACK=3
  - owner IDs: CPU=0, LDR=1
- Sub-module rr_pick2 holds the combinational winner select.
  - Inputs: two requests, last owner, lock.
  - Output: winner and valid.
  - It is reusable for future two-port arbiters.

## Test plan
- Reset, then CPU read of addr 0x3 with RAM[3] = 0xA5 -> CE high at edge k+1 only, o_CPU_ACK high at cycle k+2, o_RDATA = 0xA5, o_OWNER = 0.
- Loader write 0x3C to addr 0xF -> o_RAM_WE = 1 and o_RAM_ADDR = 0xF for one cycle, o_LDR_ACK pulses, o_RDATA unchanged.
- Both REQ high continuously for 4 transactions, lock = 0 -> ACK order CPU, LDR, CPU, LDR, each 4 cycles apart.
- Loader owns the bus, i_LDR_LOCK = 1, both REQ high for 3 transactions -> all three go to the loader. Lock drops -> the next grant goes to the CPU.
- i_RESET_n pulsed low during ACCESS of a CPU read -> outputs return to reset values asynchronously, no ACK is issued, and after release a fresh CPU request completes normally.
- CPU raises REQ in the same cycle as a loader ACK, both requesters idle before that -> the CPU is granted at the edge after ACK ends, not during ACK.
